// File: rtl/vend_pkg.sv
// Shared types and encodings for the multi-product vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } vend_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;

    localparam logic [1:0] CHG_NONE  = 2'b00;
    localparam logic [1:0] CHG_5     = 2'b01;
    localparam logic [1:0] CHG_10    = 2'b10;

    localparam int unsigned VAL_5  = 1;
    localparam int unsigned VAL_10 = 2;
    localparam int unsigned VAL_25 = 5;

    function automatic logic [2:0] coin_value(input logic [1:0] coin);
        logic [2:0] v;
        case (coin)
            COIN_5:  v = 3'(VAL_5);
            COIN_10: v = 3'(VAL_10);
            COIN_25: v = 3'(VAL_25);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Serial greedy change generator: emits one coin per step from the amount
// presented on amt; done flags that nothing is left to return.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int unsigned CRED_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic [CRED_W-1:0] amt,
    output logic [1:0]        change,
    output logic [CRED_W-1:0] amt_next,
    output logic              done
);

    logic [1:0] coin;
    logic [1:0] change_d, change_q;

    always_comb begin
        coin     = CHG_NONE;
        amt_next = '0;
        if (amt >= CRED_W'(VAL_10)) begin
            coin     = CHG_10;
            amt_next = amt - CRED_W'(VAL_10);
        end else if (amt != '0) begin
            coin     = CHG_5;
            amt_next = '0;
        end
    end

    assign done     = (amt == '0);
    assign change_d = step ? coin : CHG_NONE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            change_q <= CHG_NONE;
        end else begin
            change_q <= change_d;
        end
    end

    assign change = change_q;

endmodule

// File: rtl/vend_ctrl.sv
// Multi-product vending controller: credit FSM, price decode and change return.
// Optional inactivity auto-cancel is enabled with `define VEND_TIMEOUT_EN.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter  int unsigned NUM_PROD    = 4,
    parameter  int unsigned CRED_W      = 6,
    parameter  int unsigned MAX_CREDIT  = 40,
    parameter  int unsigned TIMEOUT_CYC = 1000,
    localparam int unsigned SEL_W       = $clog2(NUM_PROD)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 in,
    input  logic                       sel_valid,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       cancel,
    input  logic [NUM_PROD*CRED_W-1:0] prices,
    output logic                       out,
    output logic [SEL_W-1:0]           out_prod,
    output logic [1:0]                 change,
    output logic                       coin_rej,
    output logic                       nak,
    output logic [CRED_W-1:0]          credit,
    output logic                       busy
);

    vend_state_e       state_d, state_q;
    logic [CRED_W-1:0] credit_d, credit_q;
    logic              out_d, out_q;
    logic [SEL_W-1:0]  out_prod_d, out_prod_q;
    logic              nak_d, nak_q;
    logic              coin_rej_d, coin_rej_q;
    logic              busy_d, busy_q;

    logic              coin_in;
    logic              coin_fits;
    logic              coin_acc;
    logic [CRED_W:0]   sum;
    logic [CRED_W-1:0] price;
    logic              sel_ok;
    logic              cancel_eff;
    logic              step;
    logic [CRED_W-1:0] chg_amt_next;
    logic              chg_done;

    assign coin_in   = (in != COIN_NONE);
    assign sum       = {1'b0, credit_q} + (CRED_W+1)'(coin_value(in));
    assign coin_fits = (sum <= (CRED_W+1)'(MAX_CREDIT));

    always_comb begin
        price  = '0;
        sel_ok = 1'b0;
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            if (32'(sel) == i) begin
                price  = prices[i*CRED_W +: CRED_W];
                sel_ok = 1'b1;
            end
        end
    end

    // The generator steps on the current credit; credit_q tracks its remainder.
    vend_change_gen #(
        .CRED_W(CRED_W)
    ) u_change_gen (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .amt      (credit_q),
        .change   (change),
        .amt_next (chg_amt_next),
        .done     (chg_done)
    );

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        out_d      = 1'b0;
        out_prod_d = out_prod_q;
        nak_d      = 1'b0;
        coin_rej_d = 1'b0;
        step       = 1'b0;
        coin_acc   = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (cancel_eff && credit_q != '0) begin
                    state_d    = S_CHANGE;
                    step       = 1'b1;
                    credit_d   = chg_amt_next;
                    coin_rej_d = coin_in;
                end else if (sel_valid) begin
                    coin_rej_d = coin_in;
                    if (sel_ok && credit_q >= price) begin
                        state_d    = S_VEND;
                        credit_d   = credit_q - price;
                        out_d      = 1'b1;
                        out_prod_d = sel;
                    end else begin
                        nak_d = 1'b1;
                    end
                end else if (coin_in) begin
                    if (coin_fits) begin
                        state_d  = S_CREDIT;
                        credit_d = sum[CRED_W-1:0];
                        coin_acc = 1'b1;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end
            end
            S_VEND, S_CHANGE: begin
                coin_rej_d = coin_in;
                if (!chg_done) begin
                    state_d  = S_CHANGE;
                    step     = 1'b1;
                    credit_d = chg_amt_next;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_d, tmo_q;

    assign cancel_eff = cancel ||
                        ((state_q == S_CREDIT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1)));

    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (state_d != S_CREDIT || coin_acc || nak_d) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic [1:0] unused_cfg;
    assign cancel_eff = cancel;
    assign unused_cfg = {coin_acc, (TIMEOUT_CYC != 0)};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            out_q      <= 1'b0;
            out_prod_q <= '0;
            nak_q      <= 1'b0;
            coin_rej_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            out_q      <= out_d;
            out_prod_q <= out_prod_d;
            nak_q      <= nak_d;
            coin_rej_q <= coin_rej_d;
            busy_q     <= busy_d;
        end
    end

    assign out      = out_q;
    assign out_prod = out_prod_q;
    assign nak      = nak_q;
    assign coin_rej = coin_rej_q;
    assign credit   = credit_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl (prices {3,4,5,7}, 5c units).
module tb_vend_ctrl;

    localparam int unsigned NP = 4;
    localparam int unsigned CW = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [1:0]     coin = 2'b00;
    logic           sel_valid = 1'b0;
    logic [1:0]     sel = 2'd0;
    logic           cancel = 1'b0;
    logic [NP*CW-1:0] prices = {6'd7, 6'd5, 6'd4, 6'd3};

    logic           out;
    logic [1:0]     out_prod;
    logic [1:0]     change;
    logic           coin_rej;
    logic           nak;
    logic [CW-1:0]  credit;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vend_ctrl #(
        .NUM_PROD   (NP),
        .CRED_W     (CW),
        .MAX_CREDIT (40),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (coin),
        .sel_valid(sel_valid),
        .sel      (sel),
        .cancel   (cancel),
        .prices   (prices),
        .out      (out),
        .out_prod (out_prod),
        .change   (change),
        .coin_rej (coin_rej),
        .nak      (nak),
        .credit   (credit),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin = c;
        tick();
        coin = 2'b00;
    endtask

    task automatic select(input logic [1:0] s);
        sel       = s;
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("rst_out", 32'(out), 0);
        check("rst_prod", 32'(out_prod), 0);
        check("rst_change", 32'(change), 0);
        check("rst_rej", 32'(coin_rej), 0);
        check("rst_nak", 32'(nak), 0);
        check("rst_credit", 32'(credit), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b1;

        // 10c + 5c, buy product 0 (price 3): exact credit
        put_coin(2'b10);
        check("t1_credit10", 32'(credit), 2);
        put_coin(2'b01);
        check("t1_credit15", 32'(credit), 3);
        select(2'd0);
        check("t1_out", 32'(out), 1);
        check("t1_prod", 32'(out_prod), 0);
        check("t1_credit", 32'(credit), 0);
        check("t1_busy", 32'(busy), 1);
        tick();
        check("t1_out_end", 32'(out), 0);
        check("t1_change", 32'(change), 0);
        check("t1_idle", 32'(busy), 0);

        // 25c, buy product 1 (price 4), coin during VEND is rejected
        put_coin(2'b11);
        check("t2_credit", 32'(credit), 5);
        select(2'd1);
        check("t2_out", 32'(out), 1);
        check("t2_prod", 32'(out_prod), 1);
        check("t2_credit_after", 32'(credit), 1);
        coin = 2'b01;
        tick();
        coin = 2'b00;
        check("t2_change", 32'(change), 1);
        check("t2_rej_vend", 32'(coin_rej), 1);
        check("t2_credit0", 32'(credit), 0);
        check("t2_busy", 32'(busy), 1);
        tick();
        check("t2_change_end", 32'(change), 0);
        check("t2_idle", 32'(busy), 0);

        // 3 x 10c then cancel: three 10c coins back
        repeat (3) put_coin(2'b10);
        check("t3_credit", 32'(credit), 6);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t3_chg1", 32'(change), 2);
        check("t3_cr1", 32'(credit), 4);
        tick();
        check("t3_chg2", 32'(change), 2);
        tick();
        check("t3_chg3", 32'(change), 2);
        check("t3_cr3", 32'(credit), 0);
        tick();
        check("t3_chg_end", 32'(change), 0);
        check("t3_idle", 32'(busy), 0);

        // credit ceiling
        repeat (7) put_coin(2'b11);
        check("t4_cr35", 32'(credit), 35);
        put_coin(2'b10);
        put_coin(2'b01);
        check("t4_cr38", 32'(credit), 38);
        put_coin(2'b11);
        check("t4_rej25", 32'(coin_rej), 1);
        check("t4_cr38_hold", 32'(credit), 38);
        put_coin(2'b10);
        check("t4_acc_max_rej", 32'(coin_rej), 0);
        check("t4_cr40", 32'(credit), 40);
        put_coin(2'b01);
        check("t4_rej_at_max", 32'(coin_rej), 1);
        check("t4_cr40_hold", 32'(credit), 40);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t4_drain_first", 32'(change), 2);
        for (int i = 0; i < 19; i++) begin
            tick();
            check("t4_drain", 32'(change), 2);
        end
        check("t4_drain_cr", 32'(credit), 0);
        tick();
        check("t4_drain_idle", 32'(busy), 0);

        // insufficient credit for product 3
        put_coin(2'b10);
        select(2'd3);
        check("t5_nak", 32'(nak), 1);
        check("t5_out", 32'(out), 0);
        check("t5_credit", 32'(credit), 2);
        tick();
        check("t5_nak_pulse", 32'(nak), 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t5_refund", 32'(change), 2);
        tick();
        check("t5_idle", 32'(busy), 0);

        // select and coin in the same cycle: select wins, coin rejected
        put_coin(2'b11);
        coin = 2'b01;
        select(2'd2);
        coin = 2'b00;
        check("t6_out", 32'(out), 1);
        check("t6_prod", 32'(out_prod), 2);
        check("t6_rej", 32'(coin_rej), 1);
        check("t6_credit", 32'(credit), 0);
        tick();
        check("t6_idle", 32'(busy), 0);
        check("t6_no_change", 32'(change), 0);

        // zero-price product at zero credit; cancel at zero credit ignored
        prices = {6'd7, 6'd5, 6'd0, 6'd3};
        select(2'd1);
        check("t7_free_out", 32'(out), 1);
        check("t7_free_nak", 32'(nak), 0);
        tick();
        prices = {6'd7, 6'd5, 6'd4, 6'd3};
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t7_cancel0_busy", 32'(busy), 0);
        check("t7_cancel0_chg", 32'(change), 0);

        // reset during CHANGE
        put_coin(2'b11);
        put_coin(2'b11);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t8_chg", 32'(change), 2);
        check("t8_cr", 32'(credit), 8);
        rst = 1'b0;
        tick();
        check("t8_rst_chg", 32'(change), 0);
        check("t8_rst_cr", 32'(credit), 0);
        check("t8_rst_busy", 32'(busy), 0);
        check("t8_rst_out", 32'(out), 0);
        rst = 1'b1;
        tick();
        check("t8_after_chg", 32'(change), 0);
        check("t8_after_cr", 32'(credit), 0);

`ifdef VEND_TIMEOUT_EN
        put_coin(2'b01);
        repeat (7) tick();
        check("t9_tmo_wait_chg", 32'(change), 0);
        check("t9_tmo_wait_cr", 32'(credit), 1);
        tick();
        check("t9_tmo_chg", 32'(change), 1);
        check("t9_tmo_cr", 32'(credit), 0);
        tick();
        check("t9_tmo_idle", 32'(busy), 0);
`else
        put_coin(2'b01);
        repeat (100) tick();
        check("t9_hold_cr", 32'(credit), 1);
        check("t9_hold_chg", 32'(change), 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t9_refund", 32'(change), 1);
        tick();
        check("t9_idle", 32'(busy), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
